// File: rtl/digit_select_ctrl_pkg.sv
// Shared definitions for the digit selector.
// Contents:
//   step_e      - what the selector is asked to do on one clock edge
//   sel_width   - width of a digit index for a given digit count
//   count_width - width of a counter that must reach a given maximum value
package digit_select_ctrl_pkg;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DOWN = 2'd2
  } step_e;

  // Index width for n digits. Never returns zero, so a two-digit
  // selector still gets a one-bit index.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width needed to hold values 0..max_val-1 (at least one bit).
  function automatic int count_width(input int max_val);
    return (max_val <= 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/digit_select_ctrl_button.sv
// button_debounce_edge: conditions one raw push button.
// Ports:
//   clk, rst : system clock, asynchronous active-high reset
//   pb       : raw asynchronous button, high = pressed
//   held     : debounced button state
//   step     : one-cycle step request, combinational, valid on the edge
//              where held rises, plus auto-repeat requests while held
module button_debounce_edge
  import digit_select_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_BITS = 16,
  parameter int REPEAT_DELAY  = 0,
  parameter int REPEAT_PERIOD = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic pb,
  output logic held,
  output logic step
);

  logic                     sync_a;
  logic                     s;
  logic [DEBOUNCE_BITS-1:0] db_cnt;
  logic                     toggle;
  logic                     press;
  logic                     repeat_step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= 1'b0;
      s      <= 1'b0;
    end else begin
      sync_a <= pb;
      s      <= sync_a;
    end
  end

  // The debounced state flips only after s has disagreed with it for
  // 2^DEBOUNCE_BITS consecutive edges; any agreement restarts the count.
  assign toggle = (s != held) && (&db_cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt <= '0;
      held   <= 1'b0;
    end else if (s == held) begin
      db_cnt <= '0;
    end else if (toggle) begin
      held   <= ~held;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign press = toggle && !held;

  generate
    if (REPEAT_DELAY > 0) begin : g_repeat
      localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
      localparam int HOLD_W   = count_width(HOLD_MAX);

      logic [HOLD_W-1:0] hold_cnt;
      logic [HOLD_W-1:0] target;
      logic              repeating;
      logic              fire;

      // The first repeat waits REPEAT_DELAY edges after the press, later
      // ones REPEAT_PERIOD edges after the previous repeat. A release
      // taking effect on this edge suppresses the repeat.
      assign target = repeating ? HOLD_W'(REPEAT_PERIOD - 1) : HOLD_W'(REPEAT_DELAY - 1);
      assign fire   = held && !toggle && (hold_cnt == target);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          hold_cnt  <= '0;
          repeating <= 1'b0;
        end else if (press) begin
          hold_cnt  <= '0;
          repeating <= 1'b0;
        end else if (fire) begin
          hold_cnt  <= '0;
          repeating <= 1'b1;
        end else if (held) begin
          hold_cnt  <= hold_cnt + 1'b1;
        end
      end

      assign repeat_step = fire;
    end else begin : g_no_repeat
      assign repeat_step = 1'b0;
    end
  endgenerate

  assign step = press || repeat_step;

endmodule

// File: rtl/digit_select_ctrl.sv
// digit_select_ctrl: selects which of NUM_DIGITS digits is being edited.
// Ports:
//   clk, rst    : system clock, asynchronous active-high reset
//   pb_next     : raw button, steps sel up
//   pb_prev     : raw button, steps sel down
//   load        : synchronous direct-set strobe (wins over any step)
//   load_val    : value written on load, clamped to NUM_DIGITS-1
//   sel         : selected digit index
//   sel_onehot  : registered one-hot decode of sel
//   sel_changed : one-cycle pulse the cycle after sel changes value
//   next_held   : debounced pb_next
//   prev_held   : debounced pb_prev
module digit_select_ctrl
  import digit_select_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int DEBOUNCE_BITS = 16,
  parameter int REPEAT_DELAY  = 0,
  parameter int REPEAT_PERIOD = 1,
  parameter int WRAP          = 1,
  localparam int SEL_W        = sel_width(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pb_next,
  input  logic                  pb_prev,
  input  logic                  load,
  input  logic [SEL_W-1:0]      load_val,
  output logic [SEL_W-1:0]      sel,
  output logic [NUM_DIGITS-1:0] sel_onehot,
  output logic                  sel_changed,
  output logic                  next_held,
  output logic                  prev_held
);

  localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(NUM_DIGITS - 1);

  logic             step_next;
  logic             step_prev;
  step_e            step_cmd;
  logic [SEL_W-1:0] sel_nxt;

  button_debounce_edge #(
    .DEBOUNCE_BITS(DEBOUNCE_BITS),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_next (
    .clk (clk),
    .rst (rst),
    .pb  (pb_next),
    .held(next_held),
    .step(step_next)
  );

  button_debounce_edge #(
    .DEBOUNCE_BITS(DEBOUNCE_BITS),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_prev (
    .clk (clk),
    .rst (rst),
    .pb  (pb_prev),
    .held(prev_held),
    .step(step_prev)
  );

  // Opposing requests on the same edge cancel each other.
  always_comb begin
    step_cmd = STEP_NONE;
    if (step_next && !step_prev) begin
      step_cmd = STEP_UP;
    end else if (step_prev && !step_next) begin
      step_cmd = STEP_DOWN;
    end
  end

  // Load clamps out-of-range values so sel never holds an invalid code,
  // which also keeps the step arithmetic inside 0..NUM_DIGITS-1.
  always_comb begin
    sel_nxt = sel;
    if (load) begin
      sel_nxt = (load_val > MAX_SEL) ? MAX_SEL : load_val;
    end else begin
      case (step_cmd)
        STEP_UP: begin
          if (sel == MAX_SEL) begin
            sel_nxt = (WRAP != 0) ? '0 : MAX_SEL;
          end else begin
            sel_nxt = sel + 1'b1;
          end
        end
        STEP_DOWN: begin
          if (sel == '0) begin
            sel_nxt = (WRAP != 0) ? MAX_SEL : '0;
          end else begin
            sel_nxt = sel - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel         <= '0;
      sel_onehot  <= NUM_DIGITS'(1);
      sel_changed <= 1'b0;
    end else begin
      sel         <= sel_nxt;
      sel_onehot  <= NUM_DIGITS'(1) << sel_nxt;
      sel_changed <= (sel_nxt != sel);
    end
  end

endmodule

// File: tb/tb_digit_select_ctrl.sv
// Self-checking bench for digit_select_ctrl. Three configurations share
// the same button/load stimulus:
//   a : 5 digits, wrap, auto-repeat 20/8
//   b : 5 digits, saturate, no auto-repeat
//   c : 4 digits, wrap, no auto-repeat
// The reference model works from the behavioural rules: a debounced
// state flips after 16 consecutive disagreeing samples, and repeats are
// computed from the number of edges elapsed since the press.
module tb_digit_select_ctrl;

  localparam int DEBOUNCE_CYCLES = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pb_next = 1'b0;
  logic       pb_prev = 1'b0;
  logic       load = 1'b0;
  logic [2:0] load_val = 3'd0;

  logic [2:0] sel_a, sel_b;
  logic [1:0] sel_c;
  logic [4:0] oh_a, oh_b;
  logic [3:0] oh_c;
  logic [2:0] chg, nh, ph;

  always #5 clk = ~clk;

  digit_select_ctrl #(.NUM_DIGITS(5), .DEBOUNCE_BITS(4), .REPEAT_DELAY(20),
                      .REPEAT_PERIOD(8), .WRAP(1)) dut_a (
    .clk(clk), .rst(rst), .pb_next(pb_next), .pb_prev(pb_prev),
    .load(load), .load_val(load_val), .sel(sel_a), .sel_onehot(oh_a),
    .sel_changed(chg[0]), .next_held(nh[0]), .prev_held(ph[0]));

  digit_select_ctrl #(.NUM_DIGITS(5), .DEBOUNCE_BITS(4), .REPEAT_DELAY(0),
                      .REPEAT_PERIOD(1), .WRAP(0)) dut_b (
    .clk(clk), .rst(rst), .pb_next(pb_next), .pb_prev(pb_prev),
    .load(load), .load_val(load_val), .sel(sel_b), .sel_onehot(oh_b),
    .sel_changed(chg[1]), .next_held(nh[1]), .prev_held(ph[1]));

  digit_select_ctrl #(.NUM_DIGITS(4), .DEBOUNCE_BITS(4), .REPEAT_DELAY(0),
                      .REPEAT_PERIOD(1), .WRAP(1)) dut_c (
    .clk(clk), .rst(rst), .pb_next(pb_next), .pb_prev(pb_prev),
    .load(load), .load_val(load_val[1:0]), .sel(sel_c), .sel_onehot(oh_c),
    .sel_changed(chg[2]), .next_held(nh[2]), .prev_held(ph[2]));

  // Configuration of each instance as seen by the model
  int    cfgDigits[3] = '{5, 5, 4};
  int    cfgWrap[3]   = '{1, 0, 1};
  int    cfgDelay[3]  = '{20, 0, 0};
  int    cfgPeriod[3] = '{8, 1, 1};
  int    cfgMask[3]   = '{7, 7, 3};
  string instName[3]  = '{"a", "b", "c"};

  // Model state: button conditioning is common to all instances
  int syncFirst[2], syncSecond[2], runLen[2], heldM[2], sincePress[2];
  int selM[3], chgM[3];

  int checkCount = 0;
  int passCount  = 0;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed == expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", tag, $time, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int b = 0; b < 2; b++) begin
      syncFirst[b] = 0; syncSecond[b] = 0; runLen[b] = 0;
      heldM[b] = 0; sincePress[b] = 0;
    end
    for (int i = 0; i < 3; i++) begin
      selM[i] = 0; chgM[i] = 0;
    end
  endtask

  function automatic bit repeatDue(input int i, input int since);
    if (cfgDelay[i] == 0) return 1'b0;
    if (since == cfgDelay[i]) return 1'b1;
    return (since > cfgDelay[i]) && (((since - cfgDelay[i]) % cfgPeriod[i]) == 0);
  endfunction

  // One rising clock edge of the behavioural model.
  task automatic modelEdge();
    bit pressEv[2], relEv[2], wasHeld[2];
    for (int b = 0; b < 2; b++) begin
      int raw, s;
      bit flip;
      raw = (b == 0) ? int'(pb_next) : int'(pb_prev);
      s = syncSecond[b];
      syncSecond[b] = syncFirst[b];
      syncFirst[b] = raw;
      wasHeld[b] = heldM[b] != 0;
      flip = 1'b0;
      if (s != heldM[b]) begin
        runLen[b]++;
        if (runLen[b] == DEBOUNCE_CYCLES) begin
          flip = 1'b1;
          runLen[b] = 0;
        end
      end else begin
        runLen[b] = 0;
      end
      pressEv[b] = flip && !wasHeld[b];
      relEv[b]   = flip && wasHeld[b];
      if (flip) heldM[b] = 1 - heldM[b];
      if (pressEv[b]) sincePress[b] = 0;
      else if (wasHeld[b]) sincePress[b]++;
    end
    for (int i = 0; i < 3; i++) begin
      bit up, dn;
      int nxt, top, lv;
      top = cfgDigits[i] - 1;
      up = pressEv[0] || (wasHeld[0] && !relEv[0] && repeatDue(i, sincePress[0]));
      dn = pressEv[1] || (wasHeld[1] && !relEv[1] && repeatDue(i, sincePress[1]));
      nxt = selM[i];
      if (load) begin
        lv = int'(load_val) & cfgMask[i];
        nxt = (lv > top) ? top : lv;
      end else if (up && !dn) begin
        nxt = (selM[i] == top) ? ((cfgWrap[i] != 0) ? 0 : top) : selM[i] + 1;
      end else if (dn && !up) begin
        nxt = (selM[i] == 0) ? ((cfgWrap[i] != 0) ? top : 0) : selM[i] - 1;
      end
      chgM[i] = (nxt != selM[i]) ? 1 : 0;
      selM[i] = nxt;
    end
  endtask

  task automatic checkAll();
    for (int i = 0; i < 3; i++) begin
      int obsSel, obsOh;
      case (i)
        0:       begin obsSel = int'(sel_a); obsOh = int'(oh_a); end
        1:       begin obsSel = int'(sel_b); obsOh = int'(oh_b); end
        default: begin obsSel = int'(sel_c); obsOh = int'(oh_c); end
      endcase
      checkOutput($sformatf("%s.sel", instName[i]), obsSel, selM[i]);
      checkOutput($sformatf("%s.sel_onehot", instName[i]), obsOh, 1 << selM[i]);
      checkOutput($sformatf("%s.sel_changed", instName[i]), int'(chg[i]), chgM[i]);
      checkOutput($sformatf("%s.next_held", instName[i]), int'(nh[i]), heldM[0]);
      checkOutput($sformatf("%s.prev_held", instName[i]), int'(ph[i]), heldM[1]);
    end
  endtask

  // Drives inputs for one clock cycle, starting and ending on a falling edge.
  task automatic applyStimulus(input logic nx, input logic pv, input logic ld, input logic [2:0] lv);
    pb_next = nx; pb_prev = pv; load = ld; load_val = lv;
    @(posedge clk);
    if (rst) modelReset();
    else modelEdge();
    @(negedge clk);
    checkAll();
  endtask

  task automatic holdFor(input logic nx, input logic pv, input int cycles);
    for (int k = 0; k < cycles; k++) applyStimulus(nx, pv, 1'b0, 3'd0);
  endtask

  // Reset asserted between clock edges; outputs must clear at once.
  task automatic asyncReset(input logic nx);
    pb_next = nx; pb_prev = 1'b0; load = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkAll();
    @(negedge clk);
    applyStimulus(nx, 1'b0, 1'b0, 3'd0);
    applyStimulus(nx, 1'b0, 1'b0, 3'd0);
    rst = 1'b0;
  endtask

  initial begin
    logic nx, pv, ld;
    logic [2:0] lv;
    #1 rst = 1'b1;
    modelReset();
    @(negedge clk);
    checkAll();
    rst = 1'b0;

    $display("[TB] clean press with long hold");
    holdFor(1'b1, 1'b0, 40);
    holdFor(1'b0, 1'b0, 30);

    $display("[TB] separate short presses");
    for (int p = 0; p < 4; p++) begin
      holdFor(1'b1, 1'b0, 20);
      holdFor(1'b0, 1'b0, 20);
    end

    $display("[TB] bouncy press and lone glitch");
    holdFor(1'b1, 1'b0, 5);
    holdFor(1'b0, 1'b0, 3);
    holdFor(1'b1, 1'b0, 5);
    holdFor(1'b1, 1'b0, 25);
    holdFor(1'b0, 1'b0, 25);
    holdFor(1'b1, 1'b0, 15);
    holdFor(1'b0, 1'b0, 25);

    $display("[TB] down presses into the lower end");
    for (int p = 0; p < 6; p++) begin
      holdFor(1'b0, 1'b1, 20);
      holdFor(1'b0, 1'b0, 20);
    end

    $display("[TB] simultaneous presses");
    holdFor(1'b1, 1'b1, 30);
    holdFor(1'b0, 1'b0, 30);

    $display("[TB] loads");
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd7);
    holdFor(1'b0, 1'b0, 2);
    for (int k = 0; k < 17; k++) applyStimulus(1'b1, 1'b0, 1'b0, 3'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd2);
    holdFor(1'b1, 1'b0, 5);
    holdFor(1'b0, 1'b0, 25);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd2);
    holdFor(1'b0, 1'b0, 2);

    $display("[TB] auto-repeat hold");
    holdFor(1'b1, 1'b0, 70);
    holdFor(1'b0, 1'b0, 30);

    $display("[TB] randomized buttons and loads");
    nx = 1'b0; pv = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 24) == 0) nx = ~nx;
      if ($urandom_range(0, 24) == 0) pv = ~pv;
      ld = ($urandom_range(0, 29) == 0);
      lv = 3'($urandom_range(0, 7));
      applyStimulus(nx, pv, ld, lv);
    end
    holdFor(1'b0, 1'b0, 30);

    $display("[TB] reset mid-debounce, then held through reset");
    holdFor(1'b1, 1'b0, 8);
    asyncReset(1'b1);
    holdFor(1'b1, 1'b0, 30);
    holdFor(1'b0, 1'b0, 25);

    $display("[TB] reset with sel nonzero");
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd3);
    holdFor(1'b0, 1'b0, 2);
    asyncReset(1'b0);
    holdFor(1'b0, 1'b0, 5);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
